watchdog_recovery: RTL and testbench

Downstream consumer of the watchdog's active-high timeout. It converts a timeout into a controlled recovery sequence:
- interrupt and grace window for software acknowledge
- pulse on the watchdog's active-low reset_n
- optional system reset
- holdoff before re-arming
Consecutive failures are counted; exceeding the retry limit escalates to a sticky lockout that only clear_fault exits.

---
 rtl/wdt_pkg.sv | 25 ++
 rtl/wdt_cycle_timer.sv | 28 ++
 rtl/watchdog_recovery.sv | 165 ++++++++++++++++
 tb/tb_watchdog_recovery.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog recovery block: state encoding,
// default cycle constants and the retry counter width helper.
package wdt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ALERT   = 3'd1,
      ST_RESET   = 3'd2,
      ST_RECOVER = 3'd3,
      ST_LOCKOUT = 3'd4
   } state_t;

   localparam int DEF_CNT_W          = 8;
   localparam int DEF_GRACE_CYCLES   = 16;
   localparam int DEF_RESET_CYCLES   = 8;
   localparam int DEF_HOLDOFF_CYCLES = 4;
   localparam int DEF_MAX_RETRIES    = 3;
   localparam int DEF_DECAY_CYCLES   = 200;

   // Bits needed to hold 0..max_retries inclusive.
   function automatic int retry_w(input int max_retries);
      return $clog2(max_retries + 1);
   endfunction

endpackage

// File: rtl/wdt_cycle_timer.sv
// Down-counter with synchronous load; done is high while the count is zero.
// The count parks at zero until reloaded.
module wdt_cycle_timer import wdt_pkg::*; #(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   output logic             done
);

   logic [CNT_W-1:0] count;

   // Load has priority; otherwise count down and hold at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/watchdog_recovery.sv
// Watchdog recovery sequencer: turns a watchdog timeout into an
// interrupt / grace window, a watchdog reset pulse (optionally with a
// system reset), a holdoff, and a sticky lockout after too many retries.
// Optional feature macro: RECOVERY_DECAY_EN (healthy-time retry decay).
module watchdog_recovery import wdt_pkg::*; #(
   parameter int CNT_W          = DEF_CNT_W,
   parameter int GRACE_CYCLES   = DEF_GRACE_CYCLES,
   parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
   parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
   parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
   parameter int DECAY_CYCLES   = DEF_DECAY_CYCLES,
   localparam int RETRY_W       = retry_w(MAX_RETRIES)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               timeout,
   input  logic               sw_ack,
   input  logic               clear_fault,
   output logic               wdt_reset_n,
   output logic               sys_reset,
   output logic               irq,
   output logic               fault,
   output logic [RETRY_W-1:0] retry_count,
   output logic [2:0]         state_o
);

   localparam logic [CNT_W-1:0] GRACE_LOAD   = CNT_W'(GRACE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RESET_LOAD   = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLDOFF_LOAD =
      CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
   localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

   state_t             state, next_state;
   logic               timer_load, timer_done;
   logic [CNT_W-1:0]   timer_value;
   logic               wdt_reset_n_d, sys_reset_d, irq_d, fault_d;
   logic [RETRY_W-1:0] retry_d;
   logic               decay_tick;

   wdt_cycle_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (timer_load),
      .load_value (timer_value),
      .done       (timer_done)
   );

`ifdef RECOVERY_DECAY_EN
   logic healthy, decay_load, decay_done;

   // Healthy = idle with no timeout; any other cycle restarts the window.
   assign healthy    = (state == ST_IDLE) && !timeout;
   assign decay_load = !healthy || decay_done;
   assign decay_tick = healthy && decay_done && (retry_count != '0);

   wdt_cycle_timer #(.CNT_W(CNT_W)) u_decay (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (decay_load),
      .load_value (CNT_W'(DECAY_CYCLES - 1)),
      .done       (decay_done)
   );
`else
   logic unused_decay;

   assign decay_tick   = 1'b0;
   assign unused_decay = ^DECAY_CYCLES;
`endif

   // Next state, timer loads and next values of all registered outputs.
   always_comb begin
      next_state    = state;
      timer_load    = 1'b0;
      timer_value   = '0;
      wdt_reset_n_d = 1'b1;
      sys_reset_d   = 1'b0;
      irq_d         = 1'b0;
      fault_d       = 1'b0;
      retry_d       = retry_count;
      if (decay_tick) retry_d = retry_count - 1'b1;
      case (state)
         ST_IDLE: begin
            if (timeout) begin
               if (retry_count == RETRY_MAX) begin
                  next_state    = ST_LOCKOUT;
                  fault_d       = 1'b1;
                  sys_reset_d   = 1'b1;
                  wdt_reset_n_d = 1'b0;
               end else begin
                  next_state  = ST_ALERT;
                  irq_d       = 1'b1;
                  retry_d     = retry_count + 1'b1;
                  timer_load  = 1'b1;
                  timer_value = GRACE_LOAD;
               end
            end else if (clear_fault) begin
               retry_d = '0;
            end
         end
         ST_ALERT: begin
            // An ack on the final grace cycle still takes the soft path.
            if (sw_ack || timer_done) begin
               next_state    = ST_RESET;
               timer_load    = 1'b1;
               timer_value   = RESET_LOAD;
               wdt_reset_n_d = 1'b0;
               sys_reset_d   = !sw_ack;
            end
         end
         ST_RESET: begin
            wdt_reset_n_d = 1'b0;
            sys_reset_d   = sys_reset;
            if (timer_done) begin
               wdt_reset_n_d = 1'b1;
               sys_reset_d   = 1'b0;
               if (HOLDOFF_CYCLES == 0) begin
                  next_state = ST_IDLE;
               end else begin
                  next_state  = ST_RECOVER;
                  timer_load  = 1'b1;
                  timer_value = HOLDOFF_LOAD;
               end
            end
         end
         ST_RECOVER: begin
            if (timer_done) next_state = ST_IDLE;
         end
         ST_LOCKOUT: begin
            fault_d       = 1'b1;
            sys_reset_d   = 1'b1;
            wdt_reset_n_d = 1'b0;
            if (clear_fault) begin
               next_state    = ST_IDLE;
               fault_d       = 1'b0;
               sys_reset_d   = 1'b0;
               wdt_reset_n_d = 1'b1;
               retry_d       = '0;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         wdt_reset_n <= 1'b1;
         sys_reset   <= 1'b0;
         irq         <= 1'b0;
         fault       <= 1'b0;
         retry_count <= '0;
      end else begin
         state       <= next_state;
         wdt_reset_n <= wdt_reset_n_d;
         sys_reset   <= sys_reset_d;
         irq         <= irq_d;
         fault       <= fault_d;
         retry_count <= retry_d;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_watchdog_recovery.sv
// Directed bench for watchdog_recovery with default parameters.
// Decay expectations follow RECOVERY_DECAY_EN when it is defined.
module tb_watchdog_recovery;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       timeout, sw_ack, clear_fault;
   logic       wdt_reset_n, sys_reset, irq, fault;
   logic [1:0] retry_count;
   logic [2:0] state_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Clock and reset
   always #5 clk = ~clk;

   watchdog_recovery dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .timeout     (timeout),
      .sw_ack      (sw_ack),
      .clear_fault (clear_fault),
      .wdt_reset_n (wdt_reset_n),
      .sys_reset   (sys_reset),
      .irq         (irq),
      .fault       (fault),
      .retry_count (retry_count),
      .state_o     (state_o)
   );

   // Scoreboard check
   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Driver tasks: outputs are sampled 1 time unit after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count cycles with wdt_reset_n low (and sys_reset high) until release.
   task automatic measure_low(output int low_n, output int sys_n);
      low_n = 0;
      sys_n = 0;
      for (int i = 0; i < 40 && wdt_reset_n == 1'b0; i++) begin
         low_n++;
         if (sys_reset) sys_n++;
         tick();
      end
   endtask

   // Timeout, ack in ALERT, full soft recovery back to IDLE.
   task automatic soft_cycle(output int irq_v, output int retry_v);
      int low_n, sys_n;
      timeout = 1'b1;
      tick();
      timeout = 1'b0;
      irq_v   = int'(irq);
      retry_v = int'(retry_count);
      sw_ack  = 1'b1;
      tick();
      sw_ack  = 1'b0;
      measure_low(low_n, sys_n);
      repeat (4) tick();
   endtask

   initial begin
      int low_n, sys_n, alert_n, irq_v, retry_v;
      reset_n     = 1'b0;
      timeout     = 1'b0;
      sw_ack      = 1'b0;
      clear_fault = 1'b0;
      repeat (3) tick();
      check("rst_state", int'(state_o), 0);
      check("rst_wdt_reset_n", int'(wdt_reset_n), 1);
      check("rst_sys_reset", int'(sys_reset), 0);
      check("rst_irq", int'(irq), 0);
      check("rst_fault", int'(fault), 0);
      check("rst_retry", int'(retry_count), 0);
      reset_n = 1'b1;
      tick();

      // 1: soft recovery with ack five cycles after the timeout
      timeout = 1'b1;
      tick();
      timeout = 1'b0;
      check("t1_irq", int'(irq), 1);
      check("t1_state_alert", int'(state_o), 1);
      check("t1_retry", int'(retry_count), 1);
      tick();
      check("t1_irq_one_cycle", int'(irq), 0);
      repeat (3) tick();
      sw_ack = 1'b1;
      tick();
      sw_ack = 1'b0;
      check("t1_state_reset", int'(state_o), 2);
      measure_low(low_n, sys_n);
      check("t1_low_cycles", low_n, 8);
      check("t1_sys_never", sys_n, 0);
      check("t1_state_recover", int'(state_o), 3);
      repeat (3) tick();
      check("t1_still_recover", int'(state_o), 3);
      tick();
      check("t1_idle", int'(state_o), 0);

      // 2: no ack -> 16 grace cycles then hard reset
      timeout = 1'b1;
      tick();
      timeout = 1'b0;
      check("t2_retry", int'(retry_count), 2);
      alert_n = 0;
      for (int i = 0; i < 40 && state_o == 3'd1; i++) begin
         alert_n++;
         tick();
      end
      check("t2_alert_cycles", alert_n, 16);
      measure_low(low_n, sys_n);
      check("t2_low_cycles", low_n, 8);
      check("t2_sys_cycles", sys_n, 8);
      check("t2_sys_release", int'(sys_reset), 0);
      repeat (4) tick();
      check("t2_idle", int'(state_o), 0);
      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      check("t2_clear_retry", int'(retry_count), 0);

      // 3: retries 1..3, fourth timeout locks out
      for (int k = 1; k <= 3; k++) begin
         soft_cycle(irq_v, retry_v);
         check("t3_irq", irq_v, 1);
         check("t3_retry", retry_v, k);
      end
      timeout = 1'b1;
      tick();
      timeout = 1'b0;
      check("t3_lock_state", int'(state_o), 4);
      check("t3_lock_fault", int'(fault), 1);
      check("t3_lock_sys", int'(sys_reset), 1);
      check("t3_lock_wdt", int'(wdt_reset_n), 0);
      check("t3_lock_no_irq", int'(irq), 0);
      timeout = 1'b1;
      sw_ack  = 1'b1;
      repeat (3) tick();
      timeout = 1'b0;
      sw_ack  = 1'b0;
      check("t3_lock_held", int'(state_o), 4);
      check("t3_lock_retry", int'(retry_count), 3);
      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      check("t3_clr_state", int'(state_o), 0);
      check("t3_clr_fault", int'(fault), 0);
      check("t3_clr_sys", int'(sys_reset), 0);
      check("t3_clr_wdt", int'(wdt_reset_n), 1);
      check("t3_clr_retry", int'(retry_count), 0);

      // 4: ack on the last grace cycle is soft; timeout ignored in RECOVER
      timeout = 1'b1;
      tick();
      timeout = 1'b0;
      repeat (15) tick();
      check("t4_alert_last", int'(state_o), 1);
      sw_ack = 1'b1;
      tick();
      sw_ack = 1'b0;
      check("t4_state_reset", int'(state_o), 2);
      check("t4_soft_sys", int'(sys_reset), 0);
      timeout = 1'b1;
      measure_low(low_n, sys_n);
      check("t4_low_cycles", low_n, 8);
      check("t4_sys_never", sys_n, 0);
      repeat (4) tick();
      check("t4_idle_ignored", int'(state_o), 0);
      tick();
      timeout = 1'b0;
      check("t4_realert", int'(state_o), 1);
      check("t4_realert_irq", int'(irq), 1);
      check("t4_realert_retry", int'(retry_count), 2);
      sw_ack = 1'b1;
      tick();
      sw_ack = 1'b0;
      measure_low(low_n, sys_n);
      repeat (4) tick();
      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;

      // 5: async reset in the middle of a hard RESET phase
      timeout = 1'b1;
      tick();
      timeout = 1'b0;
      for (int i = 0; i < 40 && state_o == 3'd1; i++) tick();
      check("t5_hard_reset", int'(sys_reset), 1);
      repeat (3) tick();
      #2;
      reset_n = 1'b0;
      #1;
      check("t5_async_state", int'(state_o), 0);
      check("t5_async_wdt", int'(wdt_reset_n), 1);
      check("t5_async_sys", int'(sys_reset), 0);
      check("t5_async_retry", int'(retry_count), 0);
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      soft_cycle(irq_v, retry_v);
      check("t5_retry_after", retry_v, 1);

      // 6: retry decay over healthy IDLE time
      soft_cycle(irq_v, retry_v);
      check("t6_retry_start", retry_v, 2);
      repeat (199) tick();
      check("t6_before_decay", int'(retry_count), 2);
      tick();
`ifdef RECOVERY_DECAY_EN
      check("t6_decay_1", int'(retry_count), 1);
      repeat (200) tick();
      check("t6_decay_2", int'(retry_count), 0);
      repeat (250) tick();
      check("t6_decay_floor", int'(retry_count), 0);
`else
      check("t6_no_decay_1", int'(retry_count), 2);
      repeat (200) tick();
      check("t6_no_decay_2", int'(retry_count), 2);
`endif

      // Final report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
